// File: rtl/fm_param_ramp_ctrl_pkg.sv
// rtl/fm_param_ramp_ctrl_pkg.sv - shared types, defaults and helpers for the FM parameter glide controller
package fm_ctrl_pkg;

    localparam int FM_W_DEF = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    // Number of clk cycles between ramp steps.
    function automatic int tick_div(input int clkspeed, input int tick_hz);
        return clkspeed / tick_hz;
    endfunction

endpackage

// File: rtl/fm_param_ramp_ctrl_if.sv
// rtl/fm_param_ramp_ctrl_if.sv - command port carrying glide targets and step size
interface fm_param_ramp_ctrl_if #(
    parameter int FM_W = 10
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [FM_W-1:0] cmd_carrier;
    logic [FM_W-1:0] cmd_modfreq;
    logic [FM_W-1:0] cmd_depth;
    logic            cmd_gate;
    logic [FM_W-1:0] cmd_step;

    modport master (
        output cmd_valid, cmd_carrier, cmd_modfreq, cmd_depth, cmd_gate, cmd_step,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_carrier, cmd_modfreq, cmd_depth, cmd_gate, cmd_step,
        output cmd_ready
    );
endinterface

// File: rtl/fm_param_ramp_ctrl_lane.sv
// rtl/fm_param_ramp_ctrl_lane.sv - one control-word lane: current/target registers and bounded step
module fm_ramp_lane
    import fm_ctrl_pkg::*;
#(
    parameter int FM_W = FM_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            jump_i,
    input  logic            tick_en_i,
    input  logic [FM_W-1:0] target_i,
    input  logic [FM_W-1:0] step_i,
    output logic [FM_W-1:0] cur_o,
    output logic            at_target_o
);

    logic        [FM_W-1:0] cur_q;
    logic        [FM_W-1:0] tgt_q;
    logic        [FM_W-1:0] cur_d;
    logic signed [FM_W:0]   diff;
    logic        [FM_W:0]   mag;

    // Next value one step toward the target; snap when within one step so the value never overshoots or wraps.
    always_comb begin
        diff = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_q});
        mag  = diff[FM_W] ? (~diff + 1'b1) : diff;
        if (mag <= {1'b0, step_i}) begin
            cur_d = tgt_q;
        end else if (diff[FM_W]) begin
            cur_d = cur_q - step_i;
        end else begin
            cur_d = cur_q + step_i;
        end
    end

    // Target latch on accept, immediate jump when step is zero, otherwise step on each enabled tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= '0;
            tgt_q <= '0;
        end else if (load_i) begin
            tgt_q <= target_i;
            if (jump_i) begin
                cur_q <= target_i;
            end
        end else if (tick_en_i) begin
            cur_q <= cur_d;
        end
    end

    assign cur_o       = cur_q;
    assign at_target_o = (cur_q == tgt_q);

endmodule

// File: rtl/fm_param_ramp_ctrl.sv
// rtl/fm_param_ramp_ctrl.sv - glide controller stepping carrier, modulator and depth words toward command targets
module fm_param_ramp_ctrl
    import fm_ctrl_pkg::*;
#(
    parameter int FM_W     = FM_W_DEF,
    parameter int CLKSPEED = 100_000_000,
    parameter int TICK_HZ  = 1000
) (
    input  logic            clk,
    input  logic            rst,
    fm_param_ramp_ctrl_if.slave cmd,
    output logic [FM_W-1:0] carrier_freq,
    output logic [FM_W-1:0] modulator_freq,
    output logic [FM_W-1:0] mod_depth,
    output logic            busy,
    output logic            done
);

    localparam int TICK_DIV = tick_div(CLKSPEED, TICK_HZ);
    localparam int CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    generate
        if (TICK_DIV < 2) begin : g_bad_tick_div
            $error("fm_param_ramp_ctrl: CLKSPEED/TICK_HZ must be at least 2");
        end
    endgenerate

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [FM_W-1:0]  step_q;
    logic             cmd_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             stepped_q;

    logic             accept;
    logic             tick;
    logic             tick_en;
    logic             jump;
    logic [2:0]       at_tgt;
    logic             all_at;
    logic [FM_W-1:0]  depth_tgt;

    assign accept    = cmd.cmd_valid & cmd_ready_q;
    assign tick      = (cnt_q == CNT_MAX);
    assign tick_en   = tick & (state_q == RAMP) & ~accept;
    assign jump      = accept & (cmd.cmd_step == '0);
    assign all_at    = &at_tgt;
    assign depth_tgt = cmd.cmd_gate ? cmd.cmd_depth : '0;

    // Handshake, prescaler and the IDLE/RAMP FSM. Completion is evaluated on a tick (targets already met)
    // or in the cycle right after a step, so a no-op retarget still finishes on the first tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            step_q      <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stepped_q   <= 1'b0;
        end else begin
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            stepped_q   <= 1'b0;
            cnt_q       <= (accept || tick) ? '0 : cnt_q + 1'b1;
            if (accept) begin
                step_q <= cmd.cmd_step;
                if (cmd.cmd_step == '0) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= RAMP;
                    busy_q  <= 1'b1;
                end
            end else if (state_q == RAMP) begin
                if ((tick || stepped_q) && all_at) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else if (tick) begin
                    stepped_q <= 1'b1;
                end
            end
        end
    end

    fm_ramp_lane #(.FM_W(FM_W)) u_lane_carrier (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .jump_i      (jump),
        .tick_en_i   (tick_en),
        .target_i    (cmd.cmd_carrier),
        .step_i      (step_q),
        .cur_o       (carrier_freq),
        .at_target_o (at_tgt[0])
    );

    fm_ramp_lane #(.FM_W(FM_W)) u_lane_modfreq (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .jump_i      (jump),
        .tick_en_i   (tick_en),
        .target_i    (cmd.cmd_modfreq),
        .step_i      (step_q),
        .cur_o       (modulator_freq),
        .at_target_o (at_tgt[1])
    );

    fm_ramp_lane #(.FM_W(FM_W)) u_lane_depth (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .jump_i      (jump),
        .tick_en_i   (tick_en),
        .target_i    (depth_tgt),
        .step_i      (step_q),
        .cur_o       (mod_depth),
        .at_target_o (at_tgt[2])
    );

    assign cmd.cmd_ready = cmd_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_fm_param_ramp_ctrl.sv
// tb/tb_fm_param_ramp_ctrl.sv - randomized self-checking bench for fm_param_ramp_ctrl
module tb_fm_param_ramp_ctrl;

    localparam int FM_W = 10;
    localparam int TDIV = 8;

    logic            clk;
    logic            rst;
    logic [FM_W-1:0] carrier_freq;
    logic [FM_W-1:0] modulator_freq;
    logic [FM_W-1:0] mod_depth;
    logic            busy;
    logic            done;

    fm_param_ramp_ctrl_if #(.FM_W(FM_W)) cmd_if ();

    fm_param_ramp_ctrl #(
        .FM_W     (FM_W),
        .CLKSPEED (8),
        .TICK_HZ  (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd            (cmd_if),
        .carrier_freq   (carrier_freq),
        .modulator_freq (modulator_freq),
        .mod_depth      (mod_depth),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: integer lanes, glide age in cycles since the last accept.
    int m_cur [3];
    int m_tgt [3];
    int m_step;
    int m_age;
    bit m_ramp;
    bit m_chk;
    bit m_ready;
    bit m_done;

    function automatic bit m_all_at();
        return (m_cur[0] == m_tgt[0]) && (m_cur[1] == m_tgt[1]) && (m_cur[2] == m_tgt[2]);
    endfunction

    task automatic m_finish();
        m_ramp = 1'b0;
        m_done = 1'b1;
        m_chk  = 1'b0;
    endtask

    task automatic model_step();
        bit acc;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_cur[i] = 0;
                m_tgt[i] = 0;
            end
            m_step = 0; m_age = 0; m_ramp = 0; m_chk = 0; m_ready = 0; m_done = 0;
        end else begin
            acc     = cmd_if.cmd_valid && m_ready;
            m_ready = 1'b1;
            m_done  = 1'b0;
            if (acc) begin
                m_tgt[0] = int'(cmd_if.cmd_carrier);
                m_tgt[1] = int'(cmd_if.cmd_modfreq);
                m_tgt[2] = cmd_if.cmd_gate ? int'(cmd_if.cmd_depth) : 0;
                m_step   = int'(cmd_if.cmd_step);
                m_age    = 0;
                m_chk    = 0;
                if (m_step == 0) begin
                    for (int i = 0; i < 3; i++) m_cur[i] = m_tgt[i];
                    m_ramp = 0;
                    m_done = 1;
                end else begin
                    m_ramp = 1;
                end
            end else if (m_ramp) begin
                m_age++;
                if (m_age % TDIV == 0) begin
                    if (m_all_at()) begin
                        m_finish();
                    end else begin
                        for (int i = 0; i < 3; i++) begin
                            int d;
                            d = m_tgt[i] - m_cur[i];
                            if ((d < 0 ? -d : d) <= m_step) m_cur[i] = m_tgt[i];
                            else if (d < 0)                  m_cur[i] = m_cur[i] - m_step;
                            else                             m_cur[i] = m_cur[i] + m_step;
                        end
                        m_chk = 1;
                    end
                end else if (m_chk) begin
                    m_chk = 0;
                    if (m_all_at()) m_finish();
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("carrier", int'(carrier_freq), m_cur[0]);
        check("modfreq", int'(modulator_freq), m_cur[1]);
        check("depth", int'(mod_depth), m_cur[2]);
        check("busy", int'(busy), int'(m_ramp));
        check("done", int'(done), int'(m_done));
        check("ready", int'(cmd_if.cmd_ready), int'(m_ready));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input int c, input int m, input int d, input int g, input int s);
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_carrier = FM_W'(c);
        cmd_if.cmd_modfreq = FM_W'(m);
        cmd_if.cmd_depth   = FM_W'(d);
        cmd_if.cmd_gate    = g[0];
        cmd_if.cmd_step    = FM_W'(s);
        cycle();
        cmd_if.cmd_valid   = 1'b0;
    endtask

    initial begin
        int k;
        int r;
        rst                = 1'b1;
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_carrier = 10'd5;
        cmd_if.cmd_modfreq = 10'd6;
        cmd_if.cmd_depth   = 10'd7;
        cmd_if.cmd_gate    = 1'b1;
        cmd_if.cmd_step    = 10'd0;
        for (int i = 0; i < 3; i++) begin
            m_cur[i] = 0;
            m_tgt[i] = 0;
        end
        m_step = 0; m_age = 0; m_ramp = 0; m_chk = 0; m_ready = 0; m_done = 0;

        // Reset held two cycles with a command pending.
        run(2);
        check("rst_ready", int'(cmd_if.cmd_ready), 0);
        rst              = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        run(1);
        check("ready_after_rst", int'(cmd_if.cmd_ready), 1);

        // Basic glide from zero; done lands 33 cycles after the accept edge.
        send(100, 40, 30, 1, 25);
        k = 0;
        while (k < 100) begin
            cycle();
            k++;
            if (done) break;
        end
        check("done_latency", k, 33);
        check("glide_carrier_end", int'(carrier_freq), 100);
        run(3);

        // Zero step jumps immediately without entering RAMP.
        send(1023, 40, 30, 1, 0);
        check("jump_carrier", int'(carrier_freq), 1023);
        check("jump_done", int'(done), 1);
        check("jump_busy", int'(busy), 0);
        run(3);

        // Mid-ramp retarget downwards.
        send(0, 40, 30, 1, 0);
        run(2);
        send(100, 40, 30, 1, 25);
        run(16);
        check("mid_carrier", int'(carrier_freq), 50);
        send(20, 40, 30, 1, 25);
        run(8);
        check("retarget_first", int'(carrier_freq), 25);
        run(8);
        check("retarget_second", int'(carrier_freq), 20);
        run(4);

        // Release: depth falls to zero, frequencies untouched.
        send(20, 40, 99, 0, 10);
        run(40);
        check("release_depth", int'(mod_depth), 0);

        // Accept coincident with a tick, then reset mid-ramp.
        send(500, 300, 200, 1, 5);
        run(7);
        send(900, 800, 700, 1, 7);
        run(12);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        check("rst_mid_carrier", int'(carrier_freq), 0);
        run(3);

        // Randomized commands, gaps and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 249) == 0);
            cmd_if.cmd_valid = ($urandom_range(0, 29) == 0);
            cmd_if.cmd_carrier = FM_W'($urandom);
            cmd_if.cmd_modfreq = FM_W'($urandom);
            cmd_if.cmd_depth   = FM_W'($urandom);
            cmd_if.cmd_gate    = 1'($urandom);
            r = $urandom_range(0, 3);
            if (r == 0)      cmd_if.cmd_step = '0;
            else if (r == 1) cmd_if.cmd_step = FM_W'($urandom_range(1, 1023));
            else             cmd_if.cmd_step = FM_W'($urandom_range(1, 64));
            cycle();
        end
        rst              = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        run(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
